// File: rtl/sample_out_buffer.sv
// sample_out_buffer
//
// Output buffer behind the hybrid fixed-point filter. It runs on the full-rate
// clock and treats the filter's divided sample clock as data. On each rising
// edge of ds_clk it captures the filter result, if the filter reports it valid.
// The sample goes into a small circular FIFO. A consumer drains the FIFO
// through a first-word-fall-through valid/ready output register.
//
// Optional build macro:
//   SOB_TWOS_COMP_EN - invert the sample MSB on write, so out_data is two's
//                      complement instead of offset binary. Timing is unchanged.
//
// Parameters:
//   WIDTH - sample width (matches the filter's OUT_WIDTH)
//   DEPTH - FIFO entries, power of two, >= 2
//
// Ports:
//   clk       full-rate clock
//   rst       asynchronous reset, active-low
//   ds_clk    filter downsampled clock, sampled as data
//   in_data   filter output sample (offset binary)
//   in_valid  filter valid level
//   out_data  head-of-FIFO sample (registered)
//   out_valid out_data holds an unread sample
//   out_ready consumer accepts out_data this cycle
//   count     stored entries, including the one on out_data
//   overflow  sticky flag: a sample was dropped because the FIFO was full
//   clr_ovf   synchronous clear of overflow (a same-cycle drop wins)

module sample_out_buffer #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ds_clk,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic             ds_q;
  logic             stb;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic             load;
  logic [CW-1:0]    ram_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] ram [DEPTH];

  // Output-format conversion applied on the write path only.
  function automatic logic [WIDTH-1:0] fmt_sample(input logic [WIDTH-1:0] s);
`ifdef SOB_TWOS_COMP_EN
    return {~s[WIDTH-1], s[WIDTH-2:0]};
`else
    return s;
`endif
  endfunction

  always_comb begin
    stb     = ds_clk & ~ds_q;
    push    = stb & in_valid;
    pop     = out_valid & out_ready;
    // At full occupancy a write is only possible when the head leaves this cycle.
    wr_en   = push & ((count != FULL_CNT) | pop);
    drop    = push & ~wr_en;
    // Entries still in the RAM, excluding the one held in the output register.
    // A same-cycle write is not visible here, so a push into an empty FIFO
    // reaches out_data one cycle later through the normal load path.
    ram_cnt = count - CW'(out_valid);
    load    = (~out_valid | out_ready) & (ram_cnt != '0);
    wr_data = fmt_sample(in_data);
  end

  // Storage: the RAM is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_ptr] <= wr_data;
    end
  end

  // Control and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_q      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      ds_q <= ds_clk;

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (load) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_data  <= ram[rd_ptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sample_out_buffer.md
# sample_out_buffer

Output buffer downstream of the hybrid fixed-point filter top. Runs on the full-rate `clk` and treats the filter's divided sample clock as a data input. It detects each rising edge of that clock, captures the filter's `OUT_WIDTH`-bit offset-binary result while the filter reports valid, and queues it in a small FIFO. A consumer drains the FIFO through a valid/ready handshake, with occupancy and sticky overflow reporting.

## Interface
- `WIDTH`, 14: sample width; equals the filter's `OUT_WIDTH`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  full-rate clock; same clock that drives the filter's clock divider.
- `rst`  in  1  reset, asynchronous, active-low.
- `ds_clk`  in  1  filter's downsampled clock, sampled as data.
- `in_data`  in  `WIDTH`  filter output, offset binary.
- `in_valid`  in  1  filter valid flag, level.
- `out_data`  out  `WIDTH`  head-of-FIFO sample, registered.
- `out_valid`  out  1  `out_data` holds an unread sample.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `count`  out  `$clog2(DEPTH)+1`  stored entries, including the one on `out_data`.
- `overflow`  out  1  sticky: a sample was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect:
  - `ds_q` registers `ds_clk` every `clk`.
  - `stb = ds_clk & ~ds_q`.
  - The divide ratio is ≥ 2, so `in_data` is stable for at least one `clk` around `stb`.
- Push request: `push = stb & in_valid`. When `in_valid` is low, strobes are ignored and no overflow is flagged.
- Pop: `pop = out_valid & out_ready`.
- Storage:
  - Circular RAM with `$clog2(DEPTH)`-bit read and write pointers that wrap modulo `DEPTH`.
  - `count` tracks occupancy, from 0 to `DEPTH`.
- Full:
  - `push` with `count == DEPTH` and no `pop` in the same cycle: sample dropped, pointers unchanged, `overflow` set.
  - `push` and `pop` with `count == DEPTH`: write accepted, `count` unchanged.
- Empty: `pop` cannot occur (`out_valid` is low). A `push` into an empty FIFO appears on `out_data` through the normal registered path.
- Output register is first-word-fall-through. `out_data` and `out_valid` load from the RAM head whenever the register is empty or being popped and a stored entry exists.
- `out_data` is held constant while `out_valid & ~out_ready`.
- Same-cycle `push` and `pop` at any `0 < count < DEPTH`: `count` unchanged.
- `overflow`: set has priority over `clr_ovf` when both occur in the same cycle.

## Timing
- Reset values, asynchronous on `rst` low:
  - `out_data` = 0, `out_valid` = 0, `count` = 0, `overflow` = 0.
  - `ds_q` = 0, pointers = 0.
- First release:
  - First `clk` edge after release with `ds_clk` = 1 produces a strobe.
  - That is intended: the filter's `in_valid` is low after reset, so the strobe is ignored.
- Strobe latency: `ds_clk` rises before `clk` edge N, and `stb` is evaluated at edge N.
- Latency into an empty FIFO:
  - Write happens at edge N.
  - `out_valid` = 1 and `out_data` = the sample after edge N+1: two cycles from detection.
- `count` increments at edge N, so it reads 1 one cycle before `out_valid` rises.
- Throughput:
  - One push per `ds_clk` period.
  - One pop per `clk` while data is available.
- Reset asserted mid-operation discards all stored samples immediately. No partial state survives.

## Configuration
- `SOB_TWOS_COMP_EN` defined:
  - MSB of `in_data` is inverted on write, so `out_data` is two's complement.
  - Example: 14'h2000 in → 14'h0000 out; 14'h0000 in → 14'h2000 out.
- Undefined: `out_data` is bit-identical to the captured `in_data` (offset binary).
- Applies to the write path only. Timing and handshake are identical in both builds.

## Test plan
- Basic capture, `ds_clk` divide-by-12, `in_valid` = 1, `out_ready` = 1, `in_data` = 14'h1234 around one rising edge:
  - `out_valid` pulses for one cycle, two `clk` after detection, with `out_data` = 14'h1234.
  - `count` returns to 0.
- `in_valid` = 0 over 5 `ds_clk` periods: `count` stays 0, `overflow` stays 0, `out_valid` stays 0.
- Backpressure, `out_ready` = 0, DEPTH = 16, 17 strobes with values 1..17:
  - `count` = 16, `overflow` = 1, value 17 is lost.
  - Releasing `out_ready` yields 1..16 in order, with `out_data` = 1 held while stalled.
- Full with simultaneous pop: `count` = 16, and `out_ready` = 1 exactly on a strobe cycle → sample accepted, `count` stays 16, `overflow` stays 0.
- `clr_ovf` and a dropped push in the same cycle: `overflow` remains 1. `clr_ovf` alone next cycle → `overflow` = 0.
- Reset mid-stream with `count` = 7: within the reset, `out_valid`, `count` and `overflow` are all 0. After release, the next valid sample appears alone, with no stale data (also run with `SOB_TWOS_COMP_EN`: 14'h3FFF in → 14'h1FFF out).
